// File: rtl/ahb_master_burst_ctrl.sv
// AHB master burst engine: arbitrates for the bus, then runs one pipelined burst per command.
// Optional macro AHB_MASTER_ERROR_EN adds hresp and two-cycle ERROR handling.
module ahb_master_burst_ctrl #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int GRANT_TIMEOUT = 0
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic                  cmd_write,
  input  logic [2:0]            cmd_burst,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  wdata_ready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rdata_valid,
  output logic                  cmd_done,
  output logic                  cmd_err,
  output logic                  hreq,
  input  logic                  hgrant,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [2:0]            hburst,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic [DATA_WIDTH-1:0] hrdata,
  input  logic                  hwait
`ifdef AHB_MASTER_ERROR_EN
  ,
  input  logic                  hresp
`endif
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int TCW   = $clog2(GRANT_TIMEOUT + 2);
  localparam logic [TCW-1:0] T_LAST = TCW'((GRANT_TIMEOUT > 0) ? GRANT_TIMEOUT - 1 : 0);

  localparam logic [1:0] HT_IDLE   = 2'd0;
  localparam logic [1:0] HT_NONSEQ = 2'd2;
  localparam logic [1:0] HT_SEQ    = 2'd3;

  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_ADDR, ST_DRAIN, ST_ERR} state_t;

  state_t                  state, state_nxt;
  logic [ADDR_WIDTH-1:0]   cur_addr, next_addr, inc_addr, wrap_mask;
  logic [3:0]              beats_left;
  logic                    first_q, dphase_q, write_q;
  logic [2:0]              burst_q;
  logic [TCW-1:0]          tcnt;
  logic                    addr_ok, data_done, last_beat, timeout_hit, is_wrap, err_first;

  function automatic logic [4:0] beats_of(input logic [2:0] b);
    case (b)
      3'd0, 3'd1: beats_of = 5'd1;
      3'd2, 3'd3: beats_of = 5'd4;
      3'd4, 3'd5: beats_of = 5'd8;
      default:    beats_of = 5'd16;
    endcase
  endfunction

  assign haddr  = cur_addr;
  assign hwrite = write_q;
  assign hburst = burst_q;

  assign last_beat   = (beats_left == 4'd0);
  assign addr_ok     = (state == ST_ADDR) && !hwait;
  assign data_done   = dphase_q && !hwait && (state == ST_ADDR || state == ST_DRAIN);
  assign timeout_hit = (GRANT_TIMEOUT != 0) && (tcnt == T_LAST);
  assign wdata_ready = data_done && write_q;
  assign hwdata      = (dphase_q && write_q) ? wdata : '0;

`ifdef AHB_MASTER_ERROR_EN
  // First ERROR cycle: the slave holds hwait while flagging the errored data phase.
  assign err_first = dphase_q && hresp && hwait && (state == ST_ADDR || state == ST_DRAIN);
`else
  assign err_first = 1'b0;
`endif

  // Wrapping keeps the upper address bits and lets the low bits roll over inside the boundary.
  assign is_wrap   = (burst_q != 3'd0) && !burst_q[0];
  assign inc_addr  = cur_addr + ADDR_WIDTH'(BYTES);
  assign wrap_mask = ADDR_WIDTH'(beats_of(burst_q)) * ADDR_WIDTH'(BYTES) - ADDR_WIDTH'(1);
  assign next_addr = is_wrap ? ((cur_addr & ~wrap_mask) | (inc_addr & wrap_mask)) : inc_addr;

  always_ff @(posedge hclk) begin
    if (hreset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    cmd_ready = 1'b0;
    hreq      = 1'b0;
    htrans    = HT_IDLE;
    case (state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        hreq = 1'b1;
        if (hgrant)           state_nxt = ST_ADDR;
        else if (timeout_hit) state_nxt = ST_IDLE;
      end
      ST_ADDR: begin
        hreq   = 1'b1;
        htrans = first_q ? HT_NONSEQ : HT_SEQ;
        if (err_first)                 state_nxt = ST_ERR;
        else if (!hwait && last_beat)  state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (err_first)   state_nxt = ST_ERR;
        else if (!hwait) state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        if (!hwait) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      cur_addr    <= '0;
      write_q     <= 1'b0;
      burst_q     <= 3'd0;
      beats_left  <= 4'd0;
      first_q     <= 1'b0;
      dphase_q    <= 1'b0;
      tcnt        <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      cmd_done    <= 1'b0;
      cmd_err     <= 1'b0;

      if (cmd_valid && cmd_ready) begin
        cur_addr   <= cmd_addr;
        write_q    <= cmd_write;
        burst_q    <= cmd_burst;
        beats_left <= 4'(beats_of(cmd_burst) - 5'd1);
        first_q    <= 1'b1;
        tcnt       <= '0;
      end

      if (state == ST_REQ) begin
        tcnt <= tcnt + TCW'(1);
        if (!hgrant && timeout_hit) cmd_err <= 1'b1;
      end

      if (addr_ok) begin
        first_q  <= 1'b0;
        dphase_q <= 1'b1;
        if (!last_beat) begin
          cur_addr   <= next_addr;
          beats_left <= beats_left - 4'd1;
        end
      end else if (data_done && state == ST_DRAIN) begin
        dphase_q <= 1'b0;
      end

      if (data_done && !write_q) begin
        rdata       <= hrdata;
        rdata_valid <= 1'b1;
      end

      if (data_done && state == ST_DRAIN) cmd_done <= 1'b1;

      if (err_first) begin
        cmd_err  <= 1'b1;
        cmd_done <= 1'b1;
      end

      if (state == ST_ERR && !hwait) dphase_q <= 1'b0;
    end
  end

endmodule
